// File: rtl/aes_inv_cipher_core.sv
// Iterative AES inverse cipher: one inverse round per clock, S-box lanes
// instantiated per byte, round keys read combinationally from an external store.

// Combinational inverse S-box: inverse affine map, then GF(2^8) inversion (b^254).
module inverse_subByte (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] p, input logic [7:0] q);
    logic [7:0] acc, x;
    acc = '0;
    x   = p;
    for (int i = 0; i < 8; i++) begin
      if (q[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] b, x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;

  // undo affine step, then square-and-multiply up to b^254 (0 maps to 0)
  always_comb begin
    b    = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    x2   = gmul(b, b);
    x3   = gmul(x2, b);
    x6   = gmul(x3, x3);
    x7   = gmul(x6, b);
    x14  = gmul(x7, x7);
    x15  = gmul(x14, b);
    x30  = gmul(x15, x15);
    x31  = gmul(x30, b);
    x62  = gmul(x31, x31);
    x63  = gmul(x62, b);
    x126 = gmul(x63, x63);
    x127 = gmul(x126, b);
    y    = gmul(x127, x127);
  end
endmodule

module aes_inv_cipher_core #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct_in,
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt_out,
  output logic         busy
);
  localparam int         NUM_LANES = 16;
  localparam int         VEC_W     = 8;
  localparam logic [3:0] NRL       = 4'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  fsm_t         fsm;
  logic [3:0]   rnd;
  logic [127:0] st, sr, sb, ark, mc;

  // byte i lives at [127-8i -: 8]; row r = bytes r, r+4, r+8, r+12
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // {0e,0b,0d,09} multiples of one byte from a single xtime chain
  function automatic logic [31:0] mults(input logic [7:0] v);
    logic [7:0] v2, v4, v8;
    v2 = xt(v);
    v4 = xt(v2);
    v8 = xt(v4);
    return {v8 ^ v4 ^ v2, v8 ^ v2 ^ v, v8 ^ v4 ^ v, v8 ^ v};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [31:0]  m0, m1, m2, m3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      m0 = mults(s[127-32*c -: 8]);
      m1 = mults(s[119-32*c -: 8]);
      m2 = mults(s[111-32*c -: 8]);
      m3 = mults(s[103-32*c -: 8]);
      // fields: [31:24]=0e [23:16]=0b [15:8]=0d [7:0]=09
      o[127-32*c -: 8] = m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0];
      o[119-32*c -: 8] = m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8];
      o[111-32*c -: 8] = m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16];
      o[103-32*c -: 8] = m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24];
    end
    return o;
  endfunction

  assign sr = inv_shift_rows(st);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_sbox
    inverse_subByte u_sbox (
      .a(sr[(NUM_LANES-1-i)*VEC_W +: VEC_W]),
      .y(sb[(NUM_LANES-1-i)*VEC_W +: VEC_W])
    );
  end

  assign ark     = sb ^ rk_data;
  assign mc      = inv_mix_columns(ark);
  // rnd already equals NR in IDLE and 0 in FINAL/DONE
  assign rk_addr = rnd;

  // control FSM with registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      st        <= '0;
      pt_out    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      rnd       <= NRL;
    end else begin
      unique case (fsm)
        IDLE: if (in_valid) begin
          st       <= ct_in ^ rk_data;
          rnd      <= NRL - 4'd1;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          fsm      <= ROUND;
        end
        ROUND: begin
          st <= mc;
          if (rnd == 4'd1) begin
            rnd <= 4'd0;
            fsm <= FINAL;
          end else begin
            rnd <= rnd - 4'd1;
          end
        end
        FINAL: begin
          pt_out    <= ark;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          fsm       <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          rnd       <= NRL;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Scoreboard bench for aes_inv_cipher_core: directed FIPS-197 / zero-key vectors,
// an accept observer pushing expected plaintexts and a decoupled output monitor.
module tb_aes_inv_cipher_core;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] PT2 = 128'h0;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] ct_in = '0, rk_data, pt_out;
  logic         in_ready, out_valid, busy;
  logic [3:0]   rk_addr;

  always #5 clk = ~clk;

  aes_inv_cipher_core #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ct_in(ct_in), .rk_addr(rk_addr), .rk_data(rk_data),
    .out_valid(out_valid), .out_ready(out_ready), .pt_out(pt_out), .busy(busy)
  );

  // round-key store; key set follows the offered block in IDLE, the accepted one after
  logic [127:0] rks [0:1][0:15];
  logic [127:0] offer_exp = '0;
  bit           offer_key = 1'b0, act_key = 1'b0;
  assign rk_data = rks[in_ready ? offer_key : act_key][rk_addr];

  int checks = 0, failures = 0;
  int cyc = 0, n_acc = 0, last_acc = 0, prev_acc = 0, hs_cyc = 0;
  logic [127:0] exp_q[$];
  int           acc_q[$];
  logic         ov_prev = 1'b0;
  logic [127:0] pt_prev = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  // forward S-box for key expansion: brute-force inverse then affine map
  function automatic logic [7:0] gm(input logic [7:0] p, input logic [7:0] q);
    logic [7:0] acc, x;
    acc = '0; x = p;
    for (int i = 0; i < 8; i++) begin
      if (q[i]) acc ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic keyexp(input logic [127:0] key, input int k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rks[k][r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // accept observer: push the expected plaintext of the block that is about to be taken
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(offer_exp);
      acc_q.push_back(cyc + 1);
      act_key  = offer_key;
      prev_acc = last_acc;
      last_acc = cyc + 1;
      n_acc++;
    end
  end

  // output monitor: latency on rising out_valid, stability while held, compare at handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !ov_prev && acc_q.size() > 0)
        chk("latency", 128'(cyc - acc_q[0]), 128'd10);
      if (out_valid && ov_prev)
        chk("pt_stable", pt_out, pt_prev);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output: got %h expected none", pt_out);
        end else begin
          chk("pt_out", pt_out, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
        hs_cyc = cyc + 1;
      end
    end
    ov_prev = out_valid;
    pt_prev = pt_out;
  end

  task automatic send(input logic [127:0] ct, input logic [127:0] exp, input bit k);
    int start, t;
    @(posedge clk); #1;
    ct_in = ct; offer_exp = exp; offer_key = k; in_valid = 1'b1;
    start = n_acc; t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (n_acc == start && t < 40);
    in_valid = 1'b0;
    if (n_acc == start) timeout("accept");
  endtask

  task automatic wait_ov();
    int t;
    t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk); t++;
    end
    if (!out_valid) timeout("out_valid");
  endtask

  task automatic drain();
    wait_ov();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int start, t;
    keyexp(128'h000102030405060708090a0b0c0d0e0f, 0);
    keyexp(128'h0, 1);
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pt_out", pt_out, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rk_addr", rk_addr, 10);
    @(negedge clk) rst_n = 1'b1;

    // 1: FIPS-197 C.1
    send(CT1, PT1, 0);
    drain();

    // 2: zero key with rk_addr walk
    @(posedge clk); #1;
    ct_in = CT2; offer_exp = PT2; offer_key = 1; in_valid = 1'b1;
    @(negedge clk) chk("rk_addr_idle", rk_addr, 10);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 9; k >= 0; k--) begin
      @(negedge clk) chk("rk_addr_seq", rk_addr, 128'(k));
    end
    @(negedge clk);
    chk("rk_addr_done", rk_addr, 0);
    chk("ov_done", out_valid, 1);
    drain();

    // 3: back-pressure
    send(CT1, PT1, 0);
    wait_ov();
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_pt_out", pt_out, PT1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);

    // 5: reset mid-operation
    send(CT1, PT1, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("busy_before_rst", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pt_out", pt_out, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk) rst_n = 1'b1;
    send(CT1, PT1, 0);
    drain();

    // 4: second block offered while busy is ignored until after the handshake
    send(CT1, PT1, 0);
    repeat (3) @(posedge clk);
    #1;
    ct_in = CT2; offer_exp = PT2; offer_key = 1; in_valid = 1'b1;
    start = n_acc;
    wait_ov();
    repeat (2) begin
      @(negedge clk);
      chk("busy_ignore_in_ready", in_ready, 0);
      chk("busy_ignore_pt", pt_out, PT1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    t = 0;
    while (n_acc == start && t < 40) begin
      @(posedge clk); #1; t++;
    end
    in_valid = 1'b0;
    if (n_acc == start) timeout("second_accept");
    else chk("second_accept_cycle", 128'(last_acc), 128'(hs_cyc + 1));
    drain();

    // 6: back-to-back with out_ready tied high
    @(posedge clk); #1;
    ct_in = CT1; offer_exp = PT1; offer_key = 0; in_valid = 1'b1; out_ready = 1'b1;
    start = n_acc; t = 0;
    while (n_acc == start && t < 40) begin
      @(posedge clk); #1; t++;
    end
    ct_in = CT2; offer_exp = PT2; offer_key = 1;
    t = 0;
    while (n_acc < start + 2 && t < 40) begin
      @(posedge clk); #1; t++;
    end
    in_valid = 1'b0;
    if (n_acc < start + 2) timeout("b2b_accept");
    else chk("b2b_spacing", 128'(last_acc - prev_acc), 128'd12);
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk); #1; t++;
    end
    out_ready = 1'b0;

    repeat (5) @(posedge clk);
    chk("queue_empty", 128'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
